// File: rtl/mp3_pkg.sv
// Shared types for the MP3 stereo-processing slice: side info, FSM states,
// and the output FIFO entry layout.
package mp3_pkg;

    localparam int N_SAMPLES_GR = 576;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gr_state_t;

    // Per-granule side information consumed by the stereo datapath.
    typedef struct packed {
        logic [1:0]              mode;
        logic [1:0]              mode_ext;
        logic [8:0]              big_values;
        logic                    window_switching_flag;
        logic [1:0]              block_type;
        logic                    mixed_block_flag;
        logic [21:0][3:0]        scalefac_l;
        logic [12:0][2:0][3:0]   scalefac_s;
    } side_info_t;

    // One processed sample pair as it sits in the output FIFO.
    typedef struct packed {
        logic        gr;
        logic [9:0]  idx;
        logic [31:0] ch1;
        logic [31:0] ch2;
    } out_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is visible on dout whenever empty is low.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_C);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stereo_granule_sequencer.sv
// Sequences one granule of stereo samples: reads the sample buffer under a
// credit scheme, feeds the external stereo datapath, and collects its
// results into an FWFT output FIFO in index order.
module stereo_granule_sequencer
    import mp3_pkg::*;
#(
    parameter int N_SAMPLES  = N_SAMPLES_GR,
    parameter int DP_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gr_start,
    output logic        gr_ready,
    input  logic        gr_sel,
    input  side_info_t  side_in,
    output logic        buf_rd_en,
    output logic [9:0]  buf_rd_addr,
    input  logic [31:0] buf_ch1,
    input  logic [31:0] buf_ch2,
    output side_info_t  dp_side,
    output logic [31:0] dp_ch1,
    output logic [31:0] dp_ch2,
    output logic [9:0]  dp_is_pos,
    output logic        dp_gr,
    output logic        dp_din_v,
    input  logic [31:0] dp_ch1_out,
    input  logic [31:0] dp_ch2_out,
    input  logic        dp_dout_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ch1,
    output logic [31:0] out_ch2,
    output logic [9:0]  out_idx,
    output logic        out_gr,
    output logic        gr_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [9:0]  LAST_IDX = 10'(N_SAMPLES - 1);

    gr_state_t   state, state_nxt;
    logic [9:0]  rd_idx;
    logic [9:0]  ret_idx;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] fifo_cnt;
    logic        fifo_empty;
    logic        fifo_full;
    logic        credit_ok;
    logic        issue;
    logic        accept;
    logic        gr_q;
    side_info_t  side_q;
    logic        rd_vld;
    logic [9:0]  rd_addr_q;
    out_entry_t  push_entry;
    out_entry_t  head_entry;

    // Every issued read holds a credit until its result leaves the FIFO.
    assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_cnt}) < DEPTH_C;
    assign accept    = gr_start && (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        gr_ready  = 1'b0;
        gr_done   = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                gr_ready = 1'b1;
                if (gr_start) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_idx == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (in_flight == '0 && fifo_empty) state_nxt = DONE;
            end
            DONE: begin
                gr_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Granule context captured on accept and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gr_q   <= 1'b0;
            side_q <= '0;
        end else if (accept) begin
            gr_q   <= gr_sel;
            side_q <= side_in;
        end
    end

    // Read and return index counters; both restart at 0 for each granule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx  <= '0;
            ret_idx <= '0;
        end else if (accept) begin
            rd_idx  <= '0;
            ret_idx <= '0;
        end else begin
            if (issue)     rd_idx  <= rd_idx + 10'd1;
            if (dp_dout_v) ret_idx <= ret_idx + 10'd1;
        end
    end

    // Reads issued whose datapath result has not come back yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({issue, dp_dout_v})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Buffer data lands one cycle after the strobe; track which index it is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld    <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld    <= issue;
            rd_addr_q <= rd_idx;
        end
    end

    assign buf_rd_en   = issue;
    assign buf_rd_addr = rd_idx;

    assign dp_din_v  = rd_vld;
    assign dp_ch1    = rd_vld ? buf_ch1 : 32'd0;
    assign dp_ch2    = rd_vld ? buf_ch2 : 32'd0;
    assign dp_is_pos = rd_vld ? rd_addr_q : 10'd0;
    assign dp_gr     = gr_q;
    assign dp_side   = side_q;

    assign push_entry = '{gr: gr_q, idx: ret_idx, ch1: dp_ch1_out, ch2: dp_ch2_out};

    sync_fifo_fwft #(
        .WIDTH ($bits(out_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dp_dout_v),
        .din   (push_entry),
        .pop   (out_ready),
        .dout  (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    // Head fields are masked so nothing uninitialised leaks out while empty.
    assign out_valid = !fifo_empty;
    assign out_ch1   = out_valid ? head_entry.ch1 : 32'd0;
    assign out_ch2   = out_valid ? head_entry.ch2 : 32'd0;
    assign out_idx   = out_valid ? head_entry.idx : 10'd0;
    assign out_gr    = out_valid ? head_entry.gr  : 1'b0;

    a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(dp_dout_v && fifo_full && !out_ready));
    a_spurious_ret: assert property (@(posedge clk) disable iff (!rst_n)
        !(dp_dout_v && in_flight == '0));
    a_dp_latency: assert property (@(posedge clk) disable iff (!rst_n)
        dp_dout_v |-> $past(dp_din_v, DP_LATENCY));

endmodule

// File: tb/tb_stereo_granule_sequencer.sv
// Directed bench: two sequencer instances (datapath latency 2 and 5), each
// with a sample-buffer model (ch1=i, ch2=-i) and a pass-through datapath.
module tb_stereo_granule_sequencer;
    import mp3_pkg::*;

    localparam int NS = 576;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]         gr_start, gr_sel, gr_ready, buf_rd_en, dp_din_v;
    logic [1:0]         out_valid, out_ready, out_gr, gr_done;
    logic [1:0][9:0]    out_idx;
    logic [1:0][31:0]   out_ch1, out_ch2;
    side_info_t [1:0]   side_in, dp_side;

    logic [1:0] rdy_level = '0;
    logic [1:0] rnd_mode  = '0;
    logic [1:0] side_watch = '0;
    logic [1:0] exp_gr = '0;
    side_info_t side_ref [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rd_cnt[2], pop_cnt[2], bad[2], done_cnt[2], done_cyc[2], rd_at_done[2];
    int exp_next[2], credit_viol[2], side_bad[2], first_idx[2], acc_cyc[2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 2 : 5;
        logic [9:0]          buf_rd_addr, dp_is_pos;
        logic [31:0]         buf_ch1, buf_ch2, dp_ch1, dp_ch2, dp_ch1_out, dp_ch2_out;
        logic                dp_gr, dp_dout_v;
        logic [LAT-1:0]      v_sr;
        logic [LAT-1:0][31:0] c1_sr, c2_sr;

        // Sample buffer: one-cycle read latency.
        always_ff @(posedge clk) begin
            if (buf_rd_en[k]) begin
                buf_ch1 <= 32'(buf_rd_addr);
                buf_ch2 <= 32'd0 - 32'(buf_rd_addr);
            end
        end

        // Pass-through datapath with LAT cycles of delay, cleared by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_sr  <= '0;
                c1_sr <= '0;
                c2_sr <= '0;
            end else begin
                v_sr  <= {v_sr[LAT-2:0], dp_din_v[k]};
                c1_sr <= {c1_sr[LAT-2:0], dp_ch1};
                c2_sr <= {c2_sr[LAT-2:0], dp_ch2};
            end
        end
        assign dp_dout_v  = v_sr[LAT-1];
        assign dp_ch1_out = c1_sr[LAT-1];
        assign dp_ch2_out = c2_sr[LAT-1];

        stereo_granule_sequencer #(.N_SAMPLES(NS), .DP_LATENCY(LAT), .FIFO_DEPTH(8)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .gr_start(gr_start[k]), .gr_ready(gr_ready[k]), .gr_sel(gr_sel[k]),
            .side_in(side_in[k]),
            .buf_rd_en(buf_rd_en[k]), .buf_rd_addr(buf_rd_addr),
            .buf_ch1(buf_ch1), .buf_ch2(buf_ch2),
            .dp_side(dp_side[k]), .dp_ch1(dp_ch1), .dp_ch2(dp_ch2),
            .dp_is_pos(dp_is_pos), .dp_gr(dp_gr), .dp_din_v(dp_din_v[k]),
            .dp_ch1_out(dp_ch1_out), .dp_ch2_out(dp_ch2_out), .dp_dout_v(dp_dout_v),
            .out_valid(out_valid[k]), .out_ready(out_ready[k]),
            .out_ch1(out_ch1[k]), .out_ch2(out_ch2[k]), .out_idx(out_idx[k]),
            .out_gr(out_gr[k]), .gr_done(gr_done[k])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: fixed level or ~30% random.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++)
            out_ready[k] = rnd_mode[k] ? ($urandom_range(0, 99) < 30) : rdy_level[k];
    end

    // Observer: counts reads/pops, checks order and data, credit bound, side stability.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (buf_rd_en[k]) rd_cnt[k]++;
                if (rd_cnt[k] - pop_cnt[k] > 8) credit_viol[k]++;
                if (out_valid[k] && out_ready[k]) begin
                    if (pop_cnt[k] == 0) first_idx[k] = int'(out_idx[k]);
                    if (out_idx[k] != 10'(exp_next[k]) || out_ch1[k] != 32'(exp_next[k]) ||
                        out_ch2[k] != 32'd0 - 32'(exp_next[k]) || out_gr[k] != exp_gr[k])
                        bad[k]++;
                    exp_next[k] = (exp_next[k] == NS - 1) ? 0 : exp_next[k] + 1;
                    pop_cnt[k]++;
                end
                if (gr_done[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                    rd_at_done[k] = rd_cnt[k];
                end
                if (side_watch[k] && dp_side[k] !== side_ref[k]) side_bad[k]++;
            end
        end
    end

    function automatic side_info_t make_side(int seed);
        side_info_t s;
        s = '0;
        s.mode                  = 2'b01;
        s.mode_ext              = 2'(seed);
        s.big_values            = 9'(seed * 7);
        s.window_switching_flag = seed[0];
        s.block_type            = 2'(seed + 1);
        s.mixed_block_flag      = seed[1];
        s.scalefac_l[5]         = 4'(seed);
        s.scalefac_s[2][1]      = 4'(seed + 3);
        return s;
    endfunction

    task automatic clear(input int k);
        rd_cnt[k] = 0; pop_cnt[k] = 0; bad[k] = 0; done_cnt[k] = 0;
        exp_next[k] = 0; credit_viol[k] = 0; side_bad[k] = 0; first_idx[k] = -1;
    endtask

    task automatic start(input int k, input logic sel, input side_info_t s);
        @(posedge clk); #1;
        gr_sel[k] = sel; side_in[k] = s; gr_start[k] = 1'b1;
        @(posedge clk); #1;
        acc_cyc[k] = cyc;
        gr_start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && done_cnt[k] < n; i++) begin
            @(posedge clk); #1;
        end
        ok = (done_cnt[k] >= n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gr_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_gr_ready[%0d] got %b want 1", k, gr_ready[k]); end
            checks++;
            if ({buf_rd_en[k], dp_din_v[k], out_valid[k], gr_done[k], out_gr[k]} !== 5'b0) begin
                errors++; $display("FAIL reset_strobes[%0d] got %b want 00000", k,
                    {buf_rd_en[k], dp_din_v[k], out_valid[k], gr_done[k], out_gr[k]}); end
            checks++;
            if (out_idx[k] !== 10'd0 || out_ch1[k] !== 32'd0 || out_ch2[k] !== 32'd0) begin
                errors++; $display("FAIL reset_out_data[%0d] got idx=%0d ch1=%h ch2=%h want 0", k,
                    out_idx[k], out_ch1[k], out_ch2[k]); end
            checks++;
            if (dp_side[k] !== '0) begin errors++; $display("FAIL reset_dp_side[%0d] got %h want 0", k, dp_side[k]); end
        end
        checks++;
        if (g_dut[0].u_dut.fifo_cnt !== '0) begin
            errors++; $display("FAIL reset_fifo_cnt got %0d want 0", g_dut[0].u_dut.fifo_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        bit ok;
        clear(0);
        rdy_level[0] = 1'b1; exp_gr[0] = 1'b0;
        start(0, 1'b0, make_side(3));
        wait_done(0, 1, 800, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_done_timeout got done=%0d want 1", done_cnt[0]); end
        checks++;
        if (pop_cnt[0] != NS) begin errors++; $display("FAIL stream_count got %0d want %0d", pop_cnt[0], NS); end
        checks++;
        if (bad[0] != 0) begin errors++; $display("FAIL stream_data got %0d bad want 0", bad[0]); end
        checks++;
        if (done_cyc[0] - acc_cyc[0] > NS + 2 + 4) begin
            errors++; $display("FAIL stream_latency got %0d want <= %0d", done_cyc[0] - acc_cyc[0], NS + 6); end
        checks++;
        if (credit_viol[0] != 0) begin errors++; $display("FAIL stream_credit got %0d want 0", credit_viol[0]); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (done_cnt[0] != 1 || gr_ready[0] !== 1'b1) begin
            errors++; $display("FAIL stream_done_once got done=%0d ready=%b want 1 1", done_cnt[0], gr_ready[0]); end
    endtask

    task automatic test_stall;
        bit ok;
        clear(0);
        rdy_level[0] = 1'b0;
        repeat (2) @(posedge clk);
        start(0, 1'b0, make_side(5));
        repeat (60) @(posedge clk); #1;
        checks++;
        if (rd_cnt[0] != 8) begin errors++; $display("FAIL stall_reads got %0d want 8", rd_cnt[0]); end
        repeat (100) @(posedge clk); #1;
        checks++;
        if (rd_cnt[0] != 8 || buf_rd_en[0] !== 1'b0) begin
            errors++; $display("FAIL stall_reads_hold got %0d en=%b want 8 0", rd_cnt[0], buf_rd_en[0]); end
        checks++;
        if (out_valid[0] !== 1'b1 || g_dut[0].u_dut.fifo_cnt !== 4'd8) begin
            errors++; $display("FAIL stall_fifo got valid=%b cnt=%0d want 1 8", out_valid[0], g_dut[0].u_dut.fifo_cnt); end
        checks++;
        if (out_idx[0] !== 10'd0 || gr_ready[0] !== 1'b0) begin
            errors++; $display("FAIL stall_head got idx=%0d ready=%b want 0 0", out_idx[0], gr_ready[0]); end
        rdy_level[0] = 1'b1;
        wait_done(0, 1, 1000, ok);
        checks++;
        if (!ok || pop_cnt[0] != NS || bad[0] != 0) begin
            errors++; $display("FAIL stall_release got done=%0d pops=%0d bad=%0d want 1 %0d 0", done_cnt[0], pop_cnt[0], bad[0], NS); end
    endtask

    task automatic test_random_ready;
        bit ok;
        clear(0);
        rnd_mode[0] = 1'b1;
        start(0, 1'b0, make_side(6));
        wait_done(0, 1, 6000, ok);
        rnd_mode[0] = 1'b0; rdy_level[0] = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL random_timeout got done=%0d want 1", done_cnt[0]); end
        checks++;
        if (pop_cnt[0] != NS || bad[0] != 0) begin
            errors++; $display("FAIL random_seq got pops=%0d bad=%0d want %0d 0", pop_cnt[0], bad[0], NS); end
        checks++;
        if (credit_viol[0] != 0) begin errors++; $display("FAIL random_credit got %0d want 0", credit_viol[0]); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        clear(0);
        @(posedge clk); #1;
        gr_sel[0] = 1'b0; side_in[0] = make_side(1); gr_start[0] = 1'b1;
        wait_done(0, 1, 800, ok);
        checks++;
        if (!ok || pop_cnt[0] != NS || rd_at_done[0] != NS) begin
            errors++; $display("FAIL hold_first got done=%0d pops=%0d reads=%0d want 1 %0d %0d",
                done_cnt[0], pop_cnt[0], rd_at_done[0], NS, NS); end
        wait_done(0, 2, 800, ok);
        gr_start[0] = 1'b0;
        checks++;
        if (!ok || pop_cnt[0] != 2 * NS || bad[0] != 0 || rd_at_done[0] != 2 * NS) begin
            errors++; $display("FAIL hold_second got done=%0d pops=%0d bad=%0d reads=%0d want 2 %0d 0 %0d",
                done_cnt[0], pop_cnt[0], bad[0], rd_at_done[0], 2 * NS, 2 * NS); end
        repeat (20) @(posedge clk); #1;
        checks++;
        if (rd_cnt[0] != 2 * NS || done_cnt[0] != 2 || gr_ready[0] !== 1'b1) begin
            errors++; $display("FAIL hold_idle got reads=%0d done=%0d ready=%b want %0d 2 1",
                rd_cnt[0], done_cnt[0], gr_ready[0], 2 * NS); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int i;
        clear(0);
        start(0, 1'b0, make_side(2));
        for (i = 0; i < 600 && pop_cnt[0] <= 300; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pop_cnt[0] != 301) begin errors++; $display("FAIL midrst_reach got %0d want 301", pop_cnt[0]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (gr_ready[0] !== 1'b1 || {out_valid[0], buf_rd_en[0], dp_din_v[0], gr_done[0]} !== 4'b0) begin
            errors++; $display("FAIL midrst_ctrl got ready=%b strobes=%b want 1 0000", gr_ready[0],
                {out_valid[0], buf_rd_en[0], dp_din_v[0], gr_done[0]}); end
        checks++;
        if (out_idx[0] !== 10'd0 || out_ch1[0] !== 32'd0 || g_dut[0].u_dut.fifo_cnt !== '0) begin
            errors++; $display("FAIL midrst_data got idx=%0d ch1=%h cnt=%0d want 0", out_idx[0], out_ch1[0],
                g_dut[0].u_dut.fifo_cnt); end
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        clear(0);
        start(0, 1'b0, make_side(4));
        wait_done(0, 1, 800, ok);
        checks++;
        if (first_idx[0] != 0) begin errors++; $display("FAIL midrst_first_idx got %0d want 0", first_idx[0]); end
        checks++;
        if (!ok || pop_cnt[0] != NS || bad[0] != 0) begin
            errors++; $display("FAIL midrst_regranule got done=%0d pops=%0d bad=%0d want 1 %0d 0", done_cnt[0], pop_cnt[0], bad[0], NS); end
    endtask

    task automatic test_latency5;
        bit ok;
        side_info_t a;
        a = make_side(9);
        clear(1);
        rdy_level[1] = 1'b1; exp_gr[1] = 1'b1; side_ref[1] = a;
        start(1, 1'b1, a);
        side_in[1] = make_side(12);
        gr_sel[1] = 1'b0;
        side_watch[1] = 1'b1;
        wait_done(1, 1, 800, ok);
        side_watch[1] = 1'b0;
        checks++;
        if (!ok || pop_cnt[1] != NS || bad[1] != 0) begin
            errors++; $display("FAIL lat5_stream got done=%0d pops=%0d bad=%0d want 1 %0d 0", done_cnt[1], pop_cnt[1], bad[1], NS); end
        checks++;
        if (side_bad[1] != 0) begin errors++; $display("FAIL lat5_side_stable got %0d bad cycles want 0", side_bad[1]); end
        checks++;
        if (done_cyc[1] - acc_cyc[1] > NS + 5 + 4) begin
            errors++; $display("FAIL lat5_latency got %0d want <= %0d", done_cyc[1] - acc_cyc[1], NS + 9); end
        checks++;
        if (credit_viol[1] != 0) begin errors++; $display("FAIL lat5_credit got %0d want 0", credit_viol[1]); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (dp_side[1] !== a) begin errors++; $display("FAIL lat5_side_held got %h want %h", dp_side[1], a); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        gr_start = '0; gr_sel = '0; side_in = '0;
        side_ref[0] = '0; side_ref[1] = '0;
        for (int k = 0; k < 2; k++) begin
            clear(k);
            done_cyc[k] = 0; rd_at_done[k] = 0; acc_cyc[k] = 0;
        end
        test_reset();
        test_stream();
        test_stall();
        test_random_ready();
        test_back_to_back();
        test_reset_mid();
        test_latency5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
